// File: rtl/k_fifo_ctrl_t1.sv
// Synchronous first-word fall-through FIFO controller driving a small async-read dual-port RAM.
// Optional K_FIFO_LEVEL_EN adds the level and almost_full outputs.
module k_fifo_ctrl_t1 #(
   parameter int unsigned data_size = 8,
   parameter int unsigned addr_bits = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [data_size-1:0] wr_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [data_size-1:0] rd_data,
   output logic                 ram_wen,
   output logic [addr_bits-1:0] ram_waddr,
   output logic [addr_bits-1:0] ram_raddr,
   output logic [data_size-1:0] ram_d,
   input  logic [data_size-1:0] ram_q,
   output logic                 full,
   output logic                 empty,
`ifdef K_FIFO_LEVEL_EN
   output logic [addr_bits:0]   level,
   output logic                 almost_full,
`endif
   output logic                 overflow,
   output logic                 underflow
);

   localparam int unsigned Depth = 2 ** addr_bits;
   localparam logic [addr_bits:0] PtrOne = {{addr_bits{1'b0}}, 1'b1};

   logic [addr_bits:0] wptr_q, wptr_d;
   logic [addr_bits:0] rptr_q, rptr_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic               wr_acc, rd_acc;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[addr_bits-1:0] == rptr_q[addr_bits-1:0]) &&
                  (wptr_q[addr_bits] != rptr_q[addr_bits]);

   // Reset and flush both suppress the RAM write strobe in their cycle.
   assign wr_acc = wr_valid & ~full & rst_n & ~flush;
   assign rd_acc = rd_ready & ~empty & ~flush;

   assign wr_ready  = ~full;
   assign rd_valid  = ~empty;
   assign rd_data   = ram_q;
   assign ram_d     = wr_data;
   assign ram_wen   = wr_acc;
   assign ram_waddr = wptr_q[addr_bits-1:0];
   assign ram_raddr = rptr_q[addr_bits-1:0];
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

`ifdef K_FIFO_LEVEL_EN
   localparam logic [addr_bits:0] AfThresh = (addr_bits + 1)'(Depth - 1);

   assign level       = wptr_q - rptr_q;
   assign almost_full = (level >= AfThresh);
`endif

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wptr_d      = '0;
         rptr_d      = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + PtrOne;
         if (rd_acc) rptr_d = rptr_q + PtrOne;
         overflow_d  = overflow_q | (wr_valid & full);
         underflow_d = underflow_q | (rd_ready & empty);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_k_fifo_ctrl_t1.sv
// Randomized scoreboard bench for k_fifo_ctrl_t1 with an attached async-read RAM model.
// Status is checked against an occupancy model; read data is checked by a separate monitor.
module tb_k_fifo_ctrl_t1;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 1;
   localparam int          DEPTH = 2 ** AW;

   logic          clk;
   logic          rst_n, flush, wr_valid, rd_ready;
   logic [DW-1:0] wr_data;
   logic          wr_ready, rd_valid, ram_wen, full, empty, overflow, underflow;
   logic [DW-1:0] rd_data, ram_d, ram_q;
   logic [AW-1:0] ram_waddr, ram_raddr;
`ifdef K_FIFO_LEVEL_EN
   logic [AW:0]   level;
   logic          almost_full;
`endif

   k_fifo_ctrl_t1 #(.data_size(DW), .addr_bits(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
      .ram_d(ram_d), .ram_q(ram_q), .full(full), .empty(empty),
`ifdef K_FIFO_LEVEL_EN
      .level(level), .almost_full(almost_full),
`endif
      .overflow(overflow), .underflow(underflow)
   );

   // Attached RAM: synchronous write, asynchronous read.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_d;
   assign ram_q = mem[ram_raddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model
   logic [DW-1:0] exp_q [$];
   int            m_count = 0;
   int            m_wcnt  = 0;
   bit            m_ovf   = 0;
   bit            m_unf   = 0;
   bit            chk_en  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl,
                       input bit rn);
      bit wacc, racc;
      @(negedge clk);
      wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; rst_n = rn;
      #2;
      wacc = wv && (m_count < DEPTH) && rn && !fl;
      racc = rr && (m_count > 0) && rn && !fl;
      if (chk_en) begin
         check("empty", 32'(empty), 32'(m_count == 0));
         check("full", 32'(full), 32'(m_count == DEPTH));
         check("wr_ready", 32'(wr_ready), 32'(m_count != DEPTH));
         check("rd_valid", 32'(rd_valid), 32'(m_count != 0));
         check("ram_wen", 32'(ram_wen), 32'(wacc));
         if (wacc) check("ram_waddr", 32'(ram_waddr), 32'(m_wcnt % DEPTH));
         check("ram_d", 32'(ram_d), 32'(wd));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("underflow", 32'(underflow), 32'(m_unf));
`ifdef K_FIFO_LEVEL_EN
         check("level", 32'(level), 32'(m_count));
         check("almost_full", 32'(almost_full), 32'(m_count >= DEPTH - 1));
`endif
      end
      if (!rn || fl) begin
         m_count = 0; m_wcnt = 0; m_ovf = 0; m_unf = 0;
         exp_q.delete();
      end else begin
         if (wv && m_count == DEPTH) m_ovf = 1;
         if (rr && m_count == 0) m_unf = 1;
         if (racc) m_count--;
         if (wacc) begin
            exp_q.push_back(wd);
            m_count++;
            m_wcnt++;
         end
      end
   endtask

   // Monitor: every accepted read must return the oldest outstanding write.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rst_n === 1'b1 && flush === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL rd_data: read presented %0h with nothing expected at %0t",
                        rd_data, $time);
            end else begin
               check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
      // Reset with wr_valid held high; state is unknown until the first edge
      step(1, 8'h00, 0, 0, 0);
      chk_en = 1;
      step(1, 8'h00, 0, 0, 0);
      // Fill, overflow attempt, drain, underflow
      step(1, 8'hA5, 0, 0, 1);
      step(1, 8'h3C, 0, 0, 1);
      step(1, 8'h77, 0, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      step(0, 8'h00, 0, 0, 1);
      // Simultaneous read/write at occupancy 1 across pointer wraps
      step(1, 8'h11, 0, 0, 1);
      step(1, 8'h22, 1, 0, 1);
      for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 1, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      // Full with read and write together: read wins, write refused
      step(1, 8'h5A, 0, 0, 1);
      step(1, 8'hC3, 0, 0, 1);
      step(1, 8'hEE, 1, 0, 1);
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      // Flush mid-stream at occupancy 1
      step(1, 8'h44, 0, 0, 1);
      step(1, 8'h55, 1, 1, 1);
      step(0, 8'h00, 0, 0, 1);
      // Reset mid-stream at occupancy 1
      step(1, 8'h66, 0, 0, 1);
      step(1, 8'h99, 1, 0, 0);
      step(0, 8'h00, 0, 0, 1);
      // Level walk 0 -> 1 -> 2
      step(1, 8'h01, 0, 0, 1);
      step(1, 8'h02, 0, 0, 1);
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
              ($urandom_range(0, 24) == 0), !($urandom_range(0, 39) == 0));
      end
      step(0, 8'h00, 0, 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/k_fifo_ctrl_t1.md
Name: k_fifo_ctrl_t1

Overview:
- Synchronous FIFO controller that sits directly in front of the small dual-port RAM in the FIFO library.
- Drives the RAM's wen, waddr and raddr, and passes write data out to the RAM and RAM read data back to the consumer.
- Presents valid/ready handshakes on both sides with full/empty status and sticky error flags.
- Default configuration matches the 2-deep, 8-bit RAM with 1-bit addresses.

Parameters:
- data_size, 8, data width in bits; must match the attached RAM.
- addr_bits, 1, RAM address width; FIFO depth = 2**addr_bits (default 2).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst_n  input  1  synchronous reset, active-low, sampled on posedge clk.
- flush  input  1  synchronous clear of pointers and flags; lower priority than rst_n.
- wr_valid  input  1  producer has a word on wr_data.
- wr_ready  output  1  FIFO can accept a word (= ~full).
- wr_data  input  data_size  producer data.
- rd_valid  output  1  a word is available on rd_data (= ~empty).
- rd_ready  input  1  consumer takes the word this cycle.
- rd_data  output  data_size  head-of-FIFO data (= ram_q).
- ram_wen  output  1  to RAM wen.
- ram_waddr  output  addr_bits  to RAM waddr.
- ram_raddr  output  addr_bits  to RAM raddr.
- ram_d  output  data_size  to RAM d (= wr_data).
- ram_q  input  data_size  from RAM q (asynchronous read).
- full  output  1  occupancy == depth.
- empty  output  1  occupancy == 0.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Pointers: wptr and rptr are each addr_bits+1 bits wide; the MSB is the wrap bit.
  - ram_waddr = wptr[addr_bits-1:0]; ram_raddr = rptr[addr_bits-1:0].
  - empty = (wptr == rptr).
  - full = (low bits equal) and (wrap bits differ).
- Accepted write: wr_acc = wr_valid & ~full. ram_wen = wr_acc (combinational). wptr increments on that edge.
- Accepted read: rd_acc = rd_ready & ~empty. rptr increments on that edge.
- Pointers wrap modulo 2**(addr_bits+1) with no special case.
- Latency: first-word fall-through.
  - A word written at edge N gives rd_valid=1 after edge N, with rd_data = ram_q valid in the same cycle.
  - No extra register stage.
- Simultaneous read and write:
  - Neither full nor empty: both accepted and occupancy is unchanged.
  - When full: the read is accepted, the write is refused (wr_ready=0). No bypass.
  - When empty: the write is accepted, the read is refused. No write-to-read bypass.
- Errors:
  - overflow is set on any edge where wr_valid & full.
  - underflow is set on any edge where rd_ready & empty.
  - Both stay set until rst_n=0 or flush=1.
- Reset (rst_n=0 at posedge): wptr=rptr=0, overflow=underflow=0.
  - Outputs then read: empty=1, full=0, wr_ready=1, rd_valid=0, ram_wen=0 (wr_valid ignored while rst_n=0).
  - Reset mid-operation discards contents; RAM contents are not cleared.
- flush=1 with rst_n=1: same register effect as reset. Writes and reads in that cycle are discarded, and ram_wen is forced to 0.

Optional Feature:
- Macro: K_FIFO_LEVEL_EN.
- Defined:
  - Adds output level[addr_bits:0] = wptr - rptr (registered pointers, combinational subtract); ranges 0..depth.
  - Adds output almost_full = (level >= depth-1).
  - Both read 0 after reset/flush.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while driving wr_valid=1 -> empty=1, full=0, wr_ready=1, ram_wen=0, overflow=0.
- Fill to full: write 0xA5 then 0x3C on back-to-back cycles with rd_ready=0 -> ram_waddr 0 then 1, full=1 after the 2nd edge, wr_ready=0.
  - A further wr_valid=1 -> overflow=1; the RAM is not written.
- Drain: with the FIFO full, rd_ready=1 for 2 cycles -> rd_data 0xA5 then 0x3C, empty=1 after the 2nd edge.
  - Hold rd_ready=1 one more cycle -> underflow=1.
- Simultaneous at occupancy 1: write 0x11, then on the next cycle write 0x22 with rd_ready=1 -> 0x11 read, occupancy stays 1, next rd_data=0x22.
  - Verify wraparound of pointers (wrap bit toggles) over 8 such cycles with no false full/empty.
- Full plus read and write same cycle: full, wr_valid=1, rd_ready=1 -> read accepted, write refused, overflow=1, full=0 afterwards.
- Flush and reset mid-stream: occupancy 1, assert flush with wr_valid=1 -> empty=1, ram_wen=0, flags cleared.
  - Repeat with rst_n=0 -> same result.
  - With K_FIFO_LEVEL_EN defined, check level 0->1->2 and almost_full=1 at level 1 (depth 2).
